scaled_frame_scanout: RTL and testbench
=======================================

Name: scaled_frame_scanout

Overview:
Parametrised successor to the fixed 640x480 grayscale display path. It generates configurable VGA timing and scans an IMG_W x IMG_H 8-bit image out of frame memory, with integer upscaling, a programmable window position and NUM_IMAGES selectable images. Pixel colour mode is selectable at run time. It sits between the frame/io memory (read port) and the VGA DAC pins, and absorbs a fixed memory read latency so that sync, DEN and RGB stay aligned.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal front porch / sync / back porch
V_ACTIVE, 480, visible lines
V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical front porch / sync / back porch
IMG_W / IMG_H, 256 / 256, stored image size in pixels
SCALE, 1, integer upscale factor (>=1)
X0 / Y0, 0 / 0, window top-left in active coordinates
NUM_IMAGES, 2, images stored back-to-back in memory
ADDR_W, 19, memory address width
MEM_LAT, 1, memory read latency in cycles (>=1)
BG, 8'h00, grey level shown inside the active area but outside the window

Ports:
clk  in  1  pixel clock
reset  in  1  synchronous active-low reset
image_sel  in  max(1,$clog2(NUM_IMAGES))  image index; values >= NUM_IMAGES are treated as 0
mode  in  2  0 gray, 1 invert, 2 threshold, 3 false colour
mem_rd  out  1  read strobe
mem_addr  out  ADDR_W  pixel address
mem_data  in  8  pixel data, valid MEM_LAT cycles after mem_addr/mem_rd
hsync  out  1  active-low horizontal sync
vsync  out  1  active-low vertical sync
den  out  1  data enable (active area)
rgb_out  out  24  {R,G,B}
frame_start  out  1  one-cycle pulse, aligned with output pixel (0,0)

Behaviour:
- Counters: h 0..H_TOT-1 and v 0..V_TOT-1, where H_TOT and V_TOT are the sums of their four timing parameters. Region order is active, FP, sync, BP. v advances when h wraps; v wraps to 0 after V_TOT-1.
- Sync, DEN and window are computed at the counter stage (stage 0):
  - hsync low when H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC.
  - vsync low over the same pattern on v.
  - den when h < H_ACTIVE and v < V_ACTIVE.
  - win when X0 <= h < X0+IMG_W*SCALE and Y0 <= v < Y0+IMG_H*SCALE, ANDed with den.
- Latching: image_sel and mode are sampled only when (h,v)=(0,0). Changes mid-frame take effect next frame.
- Address generation (no dividers):
  - x_sub/x_img reset at each line. While win, x_sub counts 0..SCALE-1 and x_img increments when x_sub wraps.
  - y_sub/row_base advance at the end of each window line. row_base += IMG_W when y_sub wraps.
  - mem_addr = img_base + row_base + x_img, where img_base = sel*IMG_W*IMG_H (constant lookup). Registered: valid at stage 1.
  - mem_rd = win, delayed to stage 1. mem_addr holds its last value when mem_rd = 0.
- Pipeline: hsync, vsync, den, win and the latched mode are delayed so that mem_data (stage 1+MEM_LAT) pairs with its own pixel. Outputs are registered at stage PIPE = MEM_LAT+2. Every output has identical latency PIPE from the counter stage.
- Colour (g = mem_data):
  - mode 0 → {g,g,g}
  - mode 1 → {~g,~g,~g}
  - mode 2 → all FF if g>=128, else 00
  - mode 3 → {g, 8'hFF-g, g>>1}
  - den && !win → {BG,BG,BG}
  - !den → 24'h0
- frame_start: stage-0 (0,0) flag, delayed PIPE cycles.
- Reset (reset=0 at a clk edge):
  - counters, sub-counters, row_base and the pipeline clear.
  - Outputs: hsync=1, vsync=1, den=0, rgb_out=0, mem_rd=0, mem_addr=0, frame_start=0.
  - Latched sel and mode reset to 0.
  - After release, the first counter value is (0,0). frame_start pulses PIPE cycles later.
  - Reset mid-frame behaves identically (frame aborts, no partial state kept).
- Elaboration-time checks (fatal on failure):
  - X0+IMG_W*SCALE <= H_ACTIVE and Y0+IMG_H*SCALE <= V_ACTIVE.
  - NUM_IMAGES*IMG_W*IMG_H <= 2**ADDR_W.
  - SCALE >= 1 and MEM_LAT >= 1.

Decomposition:
- Package scanout_pkg:
  - colour_mode_e enum (GRAY, INVERT, THRESH, FALSE).
  - timing_t struct (active/fp/sync/bp).
  - Functions total() and clog2-safe width.
  - THRESH_LEVEL=128 constant.
- One sub-module, video_timing_gen: counters, hsync/vsync/den at stage 0, frame-origin flag. It is parametrised by the horizontal and vertical timing_t.

Test Plan (sim parameters: H 8/2/2/2, V 6/1/1/1, IMG 2x2, SCALE=2, X0=2, Y0=1, MEM_LAT=2, NUM_IMAGES=2; so PIPE=4, H_TOT=14, frame=126 cycles):
1. Release reset, hold for 2 frames → frame_start every 126 cycles, the first at cycle 4. hsync low for 2 cycles per line at line-relative outputs 14..15. vsync low during line 7. den high for 8 cycles on lines 0..5.
2. sel=0, memory returns addr as data → line v=1, h=2..5 gives mem_addr 0,0,1,1. v=2 repeats 0,0,1,1. v=3,4 give 2,2,3,3. mem_rd=0 elsewhere.
3. Set image_sel=1 at mid-frame line 2 → current frame keeps addresses 0..3. The next frame's v=1 gives 4,4,5,5.
4. mem_data=8'h30 in window → mode 0: 303030; mode 1: CFCFCF; mode 2: 000000. With mem_data=8'h80 and mode 2: FFFFFF. With 8'h30 and mode 3: 30CF18. Each new mode applies only from the next frame.
5. Set BG=8'h40 → active pixels outside the window output 404040. Blanking outputs 000000 with den=0.
6. Assert reset for 1 cycle at h=5, v=3 → outputs take their reset values the next cycle. Counters restart at (0,0). frame_start occurs 4 cycles after release, and address sequence 0,0,1,1 resumes on line 1.

Source files
------------

// File: rtl/scanout_pkg.sv
// Shared types and helpers for the scaled frame scanout path.
//   colour_mode_e : run-time pixel colour mode
//   timing_t      : one axis of video timing (active/fp/sync/bp)
//   pix_ctl_t     : per-pixel control bundle carried down the pipeline
//   total()       : sum of the four regions of one axis
//   safe_width()  : counter width for 0..n-1, never below 1 bit
//   colourise()   : maps an 8-bit grey sample to 24-bit RGB
package scanout_pkg;

  localparam int unsigned THRESH_LEVEL = 128;

  typedef enum logic [1:0] {
    GRAY   = 2'd0,
    INVERT = 2'd1,
    THRESH = 2'd2,
    FALSE  = 2'd3
  } colour_mode_e;

  typedef struct packed {
    logic [15:0] active;
    logic [15:0] fp;
    logic [15:0] sync;
    logic [15:0] bp;
  } timing_t;

  typedef struct packed {
    logic         hs;
    logic         vs;
    logic         den;
    logic         win;
    logic         org;
    colour_mode_e mode;
  } pix_ctl_t;

  localparam pix_ctl_t CTL_IDLE = '{hs: 1'b1, vs: 1'b1, den: 1'b0, win: 1'b0,
                                    org: 1'b0, mode: GRAY};

  function automatic int total(timing_t t);
    return int'(t.active) + int'(t.fp) + int'(t.sync) + int'(t.bp);
  endfunction

  function automatic int safe_width(int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic [23:0] colourise(colour_mode_e m, logic [7:0] g);
    logic [23:0] c;
    case (m)
      GRAY:    c = {3{g}};
      INVERT:  c = {3{~g}};
      THRESH:  c = (32'(g) >= THRESH_LEVEL) ? '1 : '0;
      FALSE:   c = {g, 8'hFF - g, g >> 1};
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/video_timing_gen.sv
// Free-running raster counters and stage-0 timing decode.
//   clk, reset    : pixel clock, synchronous active-low reset
//   h, v          : current raster position (active, FP, sync, BP order)
//   hsync, vsync  : active-low syncs decoded from h / v
//   den           : h and v both inside the active region
//   frame_origin  : (h,v) == (0,0)
module video_timing_gen
  import scanout_pkg::*;
#(
  parameter timing_t H_T = '{active: 16'd640, fp: 16'd16, sync: 16'd96, bp: 16'd48},
  parameter timing_t V_T = '{active: 16'd480, fp: 16'd10, sync: 16'd2,  bp: 16'd33},
  parameter int      HW  = safe_width(total(H_T)),
  parameter int      VW  = safe_width(total(V_T))
) (
  input  logic          clk,
  input  logic          reset,
  output logic [HW-1:0] h,
  output logic [VW-1:0] v,
  output logic          hsync,
  output logic          vsync,
  output logic          den,
  output logic          frame_origin
);

  localparam int H_TOT  = total(H_T);
  localparam int V_TOT  = total(V_T);
  localparam int HS_BEG = int'(H_T.active) + int'(H_T.fp);
  localparam int HS_END = HS_BEG + int'(H_T.sync);
  localparam int VS_BEG = int'(V_T.active) + int'(V_T.fp);
  localparam int VS_END = VS_BEG + int'(V_T.sync);

  always_ff @(posedge clk) begin
    if (!reset) begin
      h <= '0;
      v <= '0;
    end else if (int'(h) == H_TOT - 1) begin
      h <= '0;
      v <= (int'(v) == V_TOT - 1) ? '0 : v + 1'b1;
    end else begin
      h <= h + 1'b1;
    end
  end

  always_comb begin
    hsync        = !((int'(h) >= HS_BEG) && (int'(h) < HS_END));
    vsync        = !((int'(v) >= VS_BEG) && (int'(v) < VS_END));
    den          = (int'(h) < int'(H_T.active)) && (int'(v) < int'(V_T.active));
    frame_origin = (h == '0) && (v == '0);
  end

endmodule

// File: rtl/scaled_frame_scanout.sv
// Scans an IMG_W x IMG_H grey image out of frame memory into a VGA raster,
// with integer upscale, window offset, image select and colour modes.
//   clk, reset   : pixel clock, synchronous active-low reset
//   image_sel    : image index, sampled at frame origin (>= NUM_IMAGES -> 0)
//   mode         : colour mode, sampled at frame origin
//   mem_rd       : read strobe (stage 1)
//   mem_addr     : pixel address (stage 1, held when idle)
//   mem_data     : read data, MEM_LAT cycles after mem_addr
//   hsync, vsync : active-low syncs
//   den          : data enable
//   rgb_out      : {R,G,B}
//   frame_start  : one-cycle pulse with output pixel (0,0)
// All outputs lag the raster counters by MEM_LAT+2 cycles.
module scaled_frame_scanout
  import scanout_pkg::*;
#(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int IMG_W      = 256,
  parameter int IMG_H      = 256,
  parameter int SCALE      = 1,
  parameter int X0         = 0,
  parameter int Y0         = 0,
  parameter int NUM_IMAGES = 2,
  parameter int ADDR_W     = 19,
  parameter int MEM_LAT    = 1,
  parameter logic [7:0] BG = 8'h00,
  localparam int SEL_W     = safe_width(NUM_IMAGES)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [SEL_W-1:0]  image_sel,
  input  logic [1:0]        mode,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_data,
  output logic              hsync,
  output logic              vsync,
  output logic              den,
  output logic [23:0]       rgb_out,
  output logic              frame_start
);

  localparam timing_t H_T = '{active: 16'(H_ACTIVE), fp: 16'(H_FP),
                              sync: 16'(H_SYNC), bp: 16'(H_BP)};
  localparam timing_t V_T = '{active: 16'(V_ACTIVE), fp: 16'(V_FP),
                              sync: 16'(V_SYNC), bp: 16'(V_BP)};
  localparam int H_TOT = total(H_T);
  localparam int V_TOT = total(V_T);
  localparam int HW    = safe_width(H_TOT);
  localparam int VW    = safe_width(V_TOT);
  localparam int SUBW  = safe_width(SCALE);
  localparam int X1    = X0 + IMG_W * SCALE;
  localparam int Y1    = Y0 + IMG_H * SCALE;
  localparam int D     = MEM_LAT + 1;

  if (X1 > H_ACTIVE || Y1 > V_ACTIVE) begin : g_chk_window
    $fatal(1, "scaled window does not fit inside the active area");
  end
  if (longint'(NUM_IMAGES) * IMG_W * IMG_H > (longint'(1) << ADDR_W)) begin : g_chk_addr
    $fatal(1, "images do not fit in the address space");
  end
  if (SCALE < 1 || MEM_LAT < 1) begin : g_chk_range
    $fatal(1, "SCALE and MEM_LAT must both be at least 1");
  end

  // Stage 0: raster position and decoded timing
  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic          hs0, vs0, den0, org0, win0;

  video_timing_gen #(
    .H_T (H_T),
    .V_T (V_T),
    .HW  (HW),
    .VW  (VW)
  ) u_timing (
    .clk          (clk),
    .reset        (reset),
    .h            (h),
    .v            (v),
    .hsync        (hs0),
    .vsync        (vs0),
    .den          (den0),
    .frame_origin (org0)
  );

  // Per-frame selections; at the origin pixel itself the live inputs are used
  // so the whole frame, including pixel (0,0), sees the same values.
  logic [SEL_W-1:0] sel_q, sel_in, sel_eff;
  colour_mode_e     mode_q, mode_eff;
  logic [ADDR_W-1:0] img_base, x_img, row_base;
  logic [SUBW-1:0]   x_sub, y_sub;
  logic              line_end, frame_end, win_line_end;

  always_comb begin
    win0         = den0 && (int'(h) >= X0) && (int'(h) < X1)
                        && (int'(v) >= Y0) && (int'(v) < Y1);
    sel_in       = (int'(image_sel) < NUM_IMAGES) ? image_sel : '0;
    sel_eff      = org0 ? sel_in : sel_q;
    mode_eff     = org0 ? colour_mode_e'(mode) : mode_q;
    line_end     = (int'(h) == H_TOT - 1);
    frame_end    = line_end && (int'(v) == V_TOT - 1);
    win_line_end = win0 && (int'(h) == X1 - 1);
    img_base     = '0;
    for (int unsigned i = 0; i < NUM_IMAGES; i++) begin
      if (int'(sel_eff) == int'(i)) img_base = ADDR_W'(i * IMG_W * IMG_H);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sel_q    <= '0;
      mode_q   <= GRAY;
      x_sub    <= '0;
      x_img    <= '0;
      y_sub    <= '0;
      row_base <= '0;
      mem_rd   <= 1'b0;
      mem_addr <= '0;
    end else begin
      if (org0) begin
        sel_q  <= sel_in;
        mode_q <= colour_mode_e'(mode);
      end

      mem_rd <= win0;
      if (win0) mem_addr <= img_base + row_base + x_img;

      if (line_end) begin
        x_sub <= '0;
        x_img <= '0;
      end else if (win0) begin
        if (int'(x_sub) == SCALE - 1) begin
          x_sub <= '0;
          x_img <= x_img + 1'b1;
        end else begin
          x_sub <= x_sub + 1'b1;
        end
      end

      if (frame_end) begin
        y_sub    <= '0;
        row_base <= '0;
      end else if (win_line_end) begin
        if (int'(y_sub) == SCALE - 1) begin
          y_sub    <= '0;
          row_base <= row_base + ADDR_W'(IMG_W);
        end else begin
          y_sub <= y_sub + 1'b1;
        end
      end
    end
  end

  // Control delay line: ctl_q[D-1] lines up with mem_data for the same pixel
  pix_ctl_t ctl0;
  pix_ctl_t ctl_q [D];

  always_comb begin
    ctl0 = '{hs: hs0, vs: vs0, den: den0, win: win0, org: org0, mode: mode_eff};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned i = 0; i < D; i++) ctl_q[i] <= CTL_IDLE;
    end else begin
      ctl_q[0] <= ctl0;
      for (int unsigned i = 1; i < D; i++) ctl_q[i] <= ctl_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      den         <= 1'b0;
      rgb_out     <= '0;
      frame_start <= 1'b0;
    end else begin
      hsync       <= ctl_q[D-1].hs;
      vsync       <= ctl_q[D-1].vs;
      den         <= ctl_q[D-1].den;
      frame_start <= ctl_q[D-1].org;
      if (!ctl_q[D-1].den)      rgb_out <= '0;
      else if (!ctl_q[D-1].win) rgb_out <= {3{BG}};
      else                      rgb_out <= colourise(ctl_q[D-1].mode, mem_data);
    end
  end

endmodule

// File: tb/tb_scaled_frame_scanout.sv
// Scoreboard bench for scaled_frame_scanout on a small raster
// (H 8/2/2/2, V 6/1/1/1, 2x2 image, SCALE 2, window at (2,1), MEM_LAT 2, BG 40).
module tb_scaled_frame_scanout;

  localparam int H_TOT = 14;
  localparam int V_TOT = 9;
  localparam int FRAME = H_TOT * V_TOT;
  localparam int PIPE  = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [0:0]  image_sel = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic        mem_rd;
  logic [18:0] mem_addr;
  logic [7:0]  mem_data;
  logic        hsync, vsync, den, frame_start;
  logic [23:0] rgb_out;

  always #5 clk = ~clk;

  scaled_frame_scanout #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .IMG_W(2), .IMG_H(2), .SCALE(2), .X0(2), .Y0(1),
    .NUM_IMAGES(2), .ADDR_W(19), .MEM_LAT(2), .BG(8'h40)
  ) dut (
    .clk(clk), .reset(reset), .image_sel(image_sel), .mode(mode),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
    .hsync(hsync), .vsync(vsync), .den(den), .rgb_out(rgb_out),
    .frame_start(frame_start)
  );

  // Frame memory with a two-cycle read latency
  logic [7:0]  mem [8];
  logic [18:0] a1 = '0, a2 = '0;
  always @(posedge clk) begin
    a1 <= mem_addr;
    a2 <= a1;
  end
  assign mem_data = mem[a2[2:0]];

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        den;
    logic        fs;
    logic [23:0] rgb;
  } pix_t;

  localparam pix_t IDLE = '{hs: 1'b1, vs: 1'b1, den: 1'b0, fs: 1'b0, rgb: 24'h0};

  pix_t        pix_q [$];
  logic [18:0] addr_q [$];
  int unsigned m_t = 0;
  int          f_sel = 0, f_mode = 0;
  int          errors = 0, checks = 0;

  function automatic bit in_win(int h, int v);
    return (h >= 2 && h < 6 && v >= 1 && v < 5);
  endfunction

  function automatic int img_addr(int h, int v, int sel);
    return sel * 4 + ((v - 1) / 2) * 2 + (h - 2) / 2;
  endfunction

  function automatic pix_t expect_pixel(int h, int v, int sel, int md);
    pix_t p;
    int   g, c;
    p.hs  = !(h >= 10 && h < 12);
    p.vs  = (v != 7);
    p.den = (h < 8 && v < 6);
    p.fs  = (h == 0 && v == 0);
    if (!p.den)              c = 0;
    else if (!in_win(h, v))  c = 'h404040;
    else begin
      g = int'(mem[img_addr(h, v, sel)]);
      case (md)
        0:       c = g * 'h010101;
        1:       c = (255 - g) * 'h010101;
        2:       c = (g >= 128) ? 'hFFFFFF : 0;
        default: c = (g << 16) | ((255 - g) << 8) | (g / 2);
      endcase
    end
    p.rgb = 24'(c);
    return p;
  endfunction

  // Reference model: one raster pixel consumed per clock while out of reset
  initial forever begin
    int h, v;
    @(posedge clk);
    if (!reset) begin
      pix_q.delete();
      addr_q.delete();
      repeat (PIPE) pix_q.push_back(IDLE);
      m_t = 0; f_sel = 0; f_mode = 0;
    end else begin
      h = int'(m_t % H_TOT);
      v = int'((m_t / H_TOT) % V_TOT);
      if (h == 0 && v == 0) begin
        f_sel  = (int'(image_sel) < 2) ? int'(image_sel) : 0;
        f_mode = int'(mode);
      end
      pix_q.push_back(expect_pixel(h, v, f_sel, f_mode));
      if (in_win(h, v)) addr_q.push_back(19'(img_addr(h, v, f_sel)));
      m_t++;
    end
  end

  // Monitor: pixel stream every cycle, read strobe/address stream
  initial forever begin
    pix_t        pe;
    logic [18:0] ae;
    logic        exp_rd;
    @(negedge clk);
    if (pix_q.size() > 0) begin
      pe = pix_q.pop_front();
      checks++;
      if ({hsync, vsync, den, frame_start, rgb_out} !== pe) begin
        errors++;
        $display("FAIL pixel @%0t: got hs=%b vs=%b den=%b fs=%b rgb=%06h want hs=%b vs=%b den=%b fs=%b rgb=%06h",
                 $time, hsync, vsync, den, frame_start, rgb_out, pe.hs, pe.vs, pe.den, pe.fs, pe.rgb);
      end
      exp_rd = (addr_q.size() > 0);
      checks++;
      if (mem_rd !== exp_rd) begin
        errors++;
        $display("FAIL mem_rd @%0t: got %b want %b", $time, mem_rd, exp_rd);
      end
      if (exp_rd) begin
        ae = addr_q.pop_front();
        if (mem_rd === 1'b1) begin
          checks++;
          if (mem_addr !== ae) begin
            errors++;
            $display("FAIL mem_addr @%0t: got %0d want %0d", $time, mem_addr, ae);
          end
        end
      end
    end
  end

  task automatic wait_pos(input int h, input int v);
    int n = 0;
    bit hit = 0;
    while (!hit && n < 400) begin
      @(negedge clk);
      n++;
      hit = (int'(m_t % H_TOT) == h) && (int'((m_t / H_TOT) % V_TOT) == v);
    end
    if (!hit) begin
      checks++;
      errors++;
      $display("FAIL wait_pos: raster never reached (%0d,%0d) within 400 cycles", h, v);
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 8'($urandom);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (mem_addr !== 19'd0) begin
      errors++;
      $display("FAIL reset_addr: got %0d want 0", mem_addr);
    end
    reset = 1'b1;

    // two plain frames, image 0, grey
    repeat (2 * FRAME) @(negedge clk);

    // image select changed mid-frame: applies from the next frame
    wait_pos(0, 2);
    image_sel = 1'b1;
    repeat (2 * FRAME) @(negedge clk);

    // flat 0x30 image through every colour mode, changed mid-frame
    wait_pos(0, 7);
    for (int i = 0; i < 8; i++) mem[i] = 8'h30;
    for (int md = 0; md < 4; md++) begin
      wait_pos(4, 2);
      mode = 2'(md);
    end
    wait_pos(4, 2);

    // threshold edges
    wait_pos(0, 7);
    mem[0] = 8'h7F; mem[1] = 8'h80; mem[2] = 8'h00; mem[3] = 8'hFF;
    mem[4] = 8'h80; mem[5] = 8'h7F; mem[6] = 8'h81; mem[7] = 8'hFE;
    mode = 2'd2;
    wait_pos(4, 2);
    image_sel = 1'b0;
    wait_pos(4, 2);

    // randomized contents and selections
    for (int f = 0; f < 6; f++) begin
      wait_pos(0, 7);
      for (int i = 0; i < 8; i++) mem[i] = 8'($urandom);
      repeat ($urandom_range(1, 110)) @(negedge clk);
      mode      = 2'($urandom);
      image_sel = 1'($urandom);
    end
    wait_pos(0, 7);

    // mid-frame reset at (5,3)
    wait_pos(5, 3);
    reset     = 1'b0;
    image_sel = 1'b0;
    mode      = 2'd0;
    @(negedge clk);
    reset = 1'b1;
    repeat (2 * FRAME) @(negedge clk);
    wait_pos(0, 7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
